// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-client memory arbiter: FSM state encoding and opcode constants.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRead,
        StWrite
    } arb_state_e;

    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input grant picker (rr_arb2). With MEM_ARBITER_RR_EN it holds a last-granted pointer
// and alternates on ties; otherwise it is plain fixed priority with c0 first.
module mem_arbiter_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

`ifdef MEM_ARBITER_RR_EN
    logic last_q, last_d;

    // last_q = 1 means c1 was granted last, so c0 wins the next tie
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    assign last_d = (advance_i && (req_i != 2'b00)) ? gnt_o[1] : last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_rr;

    assign unused_rr = ^{clk_i, rst_ni, advance_i};
    assign gnt_o     = {req_i[1] & ~req_i[0], req_i[0]};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter for one memory port; the winner owns the port until its len+1 beats move.
// Define MEM_ARBITER_RR_EN for round-robin tie breaking; default build is fixed priority (c0).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LEN_BITS  = 8,
    parameter int unsigned MEM_ADDR_BITS = 32,
    parameter int unsigned MEM_DATA_BITS = 64
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     c0_req_valid,
    output logic                     c0_req_ready,
    input  logic                     c0_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
    input  logic                     c0_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
    output logic                     c0_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
    input  logic                     c0_rd_ready,

    input  logic                     c1_req_valid,
    output logic                     c1_req_ready,
    input  logic                     c1_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
    input  logic                     c1_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
    output logic                     c1_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
    input  logic                     c1_rd_ready,

    output logic                     mem_req_valid,
    output logic                     mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]  mem_req_len,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic                     mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    input  logic                     mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    output logic                     mem_rd_ready
);

    arb_state_e               state_q, state_d;
    logic [1:0]               req, gnt;
    logic                     accept, beat, last_beat;
    logic                     owner_q, opcode_q, req_valid_q;
    logic [MEM_LEN_BITS-1:0]  len_q, cnt_q;
    logic [MEM_ADDR_BITS-1:0] addr_q;

    assign req       = {c1_req_valid, c0_req_valid};
    assign accept    = (state_q == StIdle) && (req != 2'b00);
    assign last_beat = beat && (cnt_q == len_q);

    mem_arbiter_rr_arb2 u_arb (
        .clk_i     (clock),
        .rst_ni    (reset),
        .req_i     (req),
        .advance_i (accept),
        .gnt_o     (gnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:          if (accept) state_d = StReq;
            StReq:           state_d = (opcode_q == MEM_OP_RD) ? StRead : StWrite;
            StRead, StWrite: if (last_beat) state_d = StIdle;
            default:         state_d = StIdle;
        endcase
    end

    // reset gates the IDLE-state readies so every output is 0 while reset is held
    always_comb begin
        c0_req_ready = 1'b0;
        c1_req_ready = 1'b0;
        c0_rd_valid  = 1'b0;
        c1_rd_valid  = 1'b0;
        mem_rd_ready = 1'b0;
        mem_wr_valid = 1'b0;
        mem_wr_bits  = '0;
        beat         = 1'b0;
        unique case (state_q)
            StIdle: begin
                c0_req_ready = reset & gnt[0];
                c1_req_ready = reset & gnt[1];
            end
            StRead: begin
                mem_rd_ready = owner_q ? c1_rd_ready : c0_rd_ready;
                c0_rd_valid  = ~owner_q & mem_rd_valid;
                c1_rd_valid  = owner_q & mem_rd_valid;
                beat         = mem_rd_valid & mem_rd_ready;
            end
            StWrite: begin
                mem_wr_valid = owner_q ? c1_wr_valid : c0_wr_valid;
                mem_wr_bits  = owner_q ? c1_wr_bits : c0_wr_bits;
                beat         = mem_wr_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_valid_q <= 1'b0;
            owner_q     <= 1'b0;
            opcode_q    <= 1'b0;
            len_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            req_valid_q <= accept;
            if (accept) begin
                owner_q  <= gnt[1];
                opcode_q <= gnt[1] ? c1_req_opcode : c0_req_opcode;
                len_q    <= gnt[1] ? c1_req_len : c0_req_len;
                addr_q   <= gnt[1] ? c1_req_addr : c0_req_addr;
            end
            if (state_q == StReq) begin
                cnt_q <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign mem_req_valid  = req_valid_q;
    assign mem_req_opcode = opcode_q;
    assign mem_req_len    = len_q;
    assign mem_req_addr   = addr_q;

    assign c0_rd_bits = reset ? mem_rd_bits : '0;
    assign c1_rd_bits = reset ? mem_rd_bits : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: randomized traffic checked against a transaction-level
// model (owner, beats remaining, last-granted client).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef MEM_ARBITER_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        c0_req_valid, c0_req_ready, c0_req_opcode;
    logic [7:0]  c0_req_len;
    logic [31:0] c0_req_addr;
    logic        c0_wr_valid, c0_rd_valid, c0_rd_ready;
    logic [63:0] c0_wr_bits, c0_rd_bits;
    logic        c1_req_valid, c1_req_ready, c1_req_opcode;
    logic [7:0]  c1_req_len;
    logic [31:0] c1_req_addr;
    logic        c1_wr_valid, c1_rd_valid, c1_rd_ready;
    logic [63:0] c1_wr_bits, c1_rd_bits;
    logic        mem_req_valid, mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [31:0] mem_req_addr;
    logic        mem_wr_valid, mem_rd_valid, mem_rd_ready;
    logic [63:0] mem_wr_bits, mem_rd_bits;

    int   checks   = 0;
    int   failures = 0;
    logic model_last;  // client granted most recently; 1 after reset

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .c0_req_valid   (c0_req_valid),
        .c0_req_ready   (c0_req_ready),
        .c0_req_opcode  (c0_req_opcode),
        .c0_req_len     (c0_req_len),
        .c0_req_addr    (c0_req_addr),
        .c0_wr_valid    (c0_wr_valid),
        .c0_wr_bits     (c0_wr_bits),
        .c0_rd_valid    (c0_rd_valid),
        .c0_rd_bits     (c0_rd_bits),
        .c0_rd_ready    (c0_rd_ready),
        .c1_req_valid   (c1_req_valid),
        .c1_req_ready   (c1_req_ready),
        .c1_req_opcode  (c1_req_opcode),
        .c1_req_len     (c1_req_len),
        .c1_req_addr    (c1_req_addr),
        .c1_wr_valid    (c1_wr_valid),
        .c1_wr_bits     (c1_wr_bits),
        .c1_rd_valid    (c1_rd_valid),
        .c1_rd_bits     (c1_rd_bits),
        .c1_rd_ready    (c1_rd_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_opcode (mem_req_opcode),
        .mem_req_len    (mem_req_len),
        .mem_req_addr   (mem_req_addr),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_bits    (mem_wr_bits),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_bits    (mem_rd_bits),
        .mem_rd_ready   (mem_rd_ready)
    );

    task automatic drive_quiet();
        c0_req_valid = 1'b0; c0_req_opcode = 1'b0; c0_req_len = '0; c0_req_addr = '0;
        c0_wr_valid  = 1'b0; c0_wr_bits    = '0;   c0_rd_ready = 1'b0;
        c1_req_valid = 1'b0; c1_req_opcode = 1'b0; c1_req_len = '0; c1_req_addr = '0;
        c1_wr_valid  = 1'b0; c1_wr_bits    = '0;   c1_rd_ready = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_bits   = '0;
    endtask

    task automatic test_reset();
        logic [63:0] data;
        @(negedge clock);
        reset = 1'b0;
        drive_quiet();
        data = {$urandom, $urandom};
        c0_req_valid = 1'b1; c1_req_valid = 1'b1; c0_rd_ready = 1'b1; c1_rd_ready = 1'b1;
        c0_wr_valid  = 1'b1; c1_wr_valid  = 1'b1; mem_rd_valid = 1'b1;
        mem_rd_bits  = data; c0_wr_bits   = data; c1_wr_bits  = data;
        #1;
        checks++;
        if ({c0_req_ready, c1_req_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_req_ready got c0=%b c1=%b want 0 0", c0_req_ready, c1_req_ready);
        end
        checks++;
        if ({mem_req_valid, mem_rd_ready, mem_wr_valid, c0_rd_valid, c1_rd_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_valids got req=%b rdy=%b wr=%b rv0=%b rv1=%b want all 0",
                     mem_req_valid, mem_rd_ready, mem_wr_valid, c0_rd_valid, c1_rd_valid);
        end
        checks++;
        if (mem_req_opcode !== 1'b0 || mem_req_len !== 8'd0 || mem_req_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_req_fields got op=%b len=%0d addr=%h want 0 0 0",
                     mem_req_opcode, mem_req_len, mem_req_addr);
        end
        checks++;
        if (mem_wr_bits !== 64'd0 || c0_rd_bits !== 64'd0 || c1_rd_bits !== 64'd0) begin
            failures++;
            $display("FAIL reset_data got wr=%h rd0=%h rd1=%h want 0", mem_wr_bits, c0_rd_bits,
                     c1_rd_bits);
        end
        @(negedge clock);
        drive_quiet();
        reset = 1'b1;
        model_last = 1'b1;
    endtask

    // mode 0: memory/client always ready; mode 1: client stalls 3 cycles on beat 2; mode 2: random
    task automatic test_read(input logic cl, input int len, input logic [31:0] addr,
                             input int mode);
        logic [7:0]  lenv;
        logic [63:0] data, own_bits;
        logic        mv, rdy, own_v, oth_v;
        int          left, seen, stall, cyc;
        lenv = len[7:0];
        @(negedge clock);
        drive_quiet();
        if (cl) begin
            c1_req_valid = 1'b1; c1_req_opcode = MEM_OP_RD; c1_req_len = lenv; c1_req_addr = addr;
        end else begin
            c0_req_valid = 1'b1; c0_req_opcode = MEM_OP_RD; c0_req_len = lenv; c0_req_addr = addr;
        end
        #1;
        checks++;
        if ({c1_req_ready, c0_req_ready} !== (cl ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL read_accept got c1=%b c0=%b want only c%0d", c1_req_ready, c0_req_ready,
                     cl);
        end
        model_last = cl;
        @(negedge clock);
        c0_req_valid = 1'b0; c1_req_valid = 1'b0;
        c0_req_addr = $urandom; c1_req_addr = $urandom;
        c0_req_len = 8'($urandom); c1_req_len = 8'($urandom);
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_opcode !== MEM_OP_RD || mem_req_len !== lenv ||
            mem_req_addr !== addr) begin
            failures++;
            $display("FAIL read_req got v=%b op=%b len=%0d addr=%h want 1 0 %0d %h", mem_req_valid,
                     mem_req_opcode, mem_req_len, mem_req_addr, lenv, addr);
        end
        left = len + 1; seen = 0; stall = 0; cyc = 0;
        while (left > 0 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            mv = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 1 && seen == 1 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else if (mode == 2) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            data = {$urandom, $urandom};
            mem_rd_valid = mv; mem_rd_bits = data;
            c0_rd_ready = cl ? 1'($urandom_range(0, 1)) : rdy;
            c1_rd_ready = cl ? rdy : 1'($urandom_range(0, 1));
            c0_wr_valid = 1'($urandom_range(0, 1)); c1_wr_valid = 1'($urandom_range(0, 1));
            #1;
            own_v    = cl ? c1_rd_valid : c0_rd_valid;
            oth_v    = cl ? c0_rd_valid : c1_rd_valid;
            own_bits = cl ? c1_rd_bits : c0_rd_bits;
            checks++;
            if (own_v !== mv || oth_v !== 1'b0) begin
                failures++;
                $display("FAIL read_valid beat=%0d got own=%b other=%b want own=%b other=0", seen,
                         own_v, oth_v, mv);
            end
            checks++;
            if (mem_rd_ready !== rdy || mem_wr_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL read_ready beat=%0d got rdy=%b wr=%b req=%b want %b 0 0", seen,
                         mem_rd_ready, mem_wr_valid, mem_req_valid, rdy);
            end
            if (mv) begin
                checks++;
                if (own_bits !== data) begin
                    failures++;
                    $display("FAIL read_data beat=%0d got %h want %h", seen, own_bits, data);
                end
            end
            if (mv && rdy) begin
                left--;
                seen++;
            end
        end
        if (left != 0) begin
            failures++;
            $display("FAIL read_budget beats left=%0d want 0", left);
        end
        @(negedge clock);
        mem_rd_valid = 1'b1; c0_rd_ready = 1'b1; c1_rd_ready = 1'b1;
        c0_wr_valid = 1'b0; c1_wr_valid = 1'b0;
        #1;
        checks++;
        if (mem_rd_ready !== 1'b0 || c0_rd_valid !== 1'b0 || c1_rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_idle got rdy=%b rv0=%b rv1=%b want 0 0 0", mem_rd_ready,
                     c0_rd_valid, c1_rd_valid);
        end
        drive_quiet();
    endtask

    // mode 0: owner beats back to back with data base, base+1, ...; else random gaps and data
    task automatic test_write(input logic cl, input int len, input logic [31:0] addr,
                              input logic [63:0] base, input int mode);
        logic [7:0]  lenv;
        logic [63:0] data, junk;
        logic        wv;
        int          left, seen, cyc;
        lenv = len[7:0];
        @(negedge clock);
        drive_quiet();
        if (cl) begin
            c1_req_valid = 1'b1; c1_req_opcode = MEM_OP_WR; c1_req_len = lenv; c1_req_addr = addr;
        end else begin
            c0_req_valid = 1'b1; c0_req_opcode = MEM_OP_WR; c0_req_len = lenv; c0_req_addr = addr;
        end
        #1;
        checks++;
        if ({c1_req_ready, c0_req_ready} !== (cl ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL write_accept got c1=%b c0=%b want only c%0d", c1_req_ready,
                     c0_req_ready, cl);
        end
        model_last = cl;
        @(negedge clock);
        c0_req_valid = 1'b0; c1_req_valid = 1'b0;
        c0_req_opcode = 1'b0; c1_req_opcode = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_opcode !== MEM_OP_WR || mem_req_len !== lenv ||
            mem_req_addr !== addr || mem_wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_req got v=%b op=%b len=%0d addr=%h wr=%b want 1 1 %0d %h 0",
                     mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr, mem_wr_valid,
                     lenv, addr);
        end
        left = len + 1; seen = 0; cyc = 0;
        while (left > 0 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            wv   = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            data = (mode == 0) ? base + 64'(seen) : {$urandom, $urandom};
            junk = {$urandom, $urandom};
            if (cl) begin
                c1_wr_valid = wv; c1_wr_bits = data; c0_wr_valid = cyc[0]; c0_wr_bits = junk;
            end else begin
                c0_wr_valid = wv; c0_wr_bits = data; c1_wr_valid = cyc[0]; c1_wr_bits = junk;
            end
            mem_rd_valid = 1'($urandom_range(0, 1));
            c0_rd_ready = 1'($urandom_range(0, 1)); c1_rd_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (mem_wr_valid !== wv) begin
                failures++;
                $display("FAIL write_valid beat=%0d got %b want %b", seen, mem_wr_valid, wv);
            end
            if (wv) begin
                checks++;
                if (mem_wr_bits !== data) begin
                    failures++;
                    $display("FAIL write_data beat=%0d got %h want %h", seen, mem_wr_bits, data);
                end
            end
            checks++;
            if (mem_rd_ready !== 1'b0 || c0_rd_valid !== 1'b0 || c1_rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL write_rd_quiet got rdy=%b rv0=%b rv1=%b want 0 0 0", mem_rd_ready,
                         c0_rd_valid, c1_rd_valid);
            end
            if (wv) begin
                left--;
                seen++;
            end
        end
        if (left != 0) begin
            failures++;
            $display("FAIL write_budget beats left=%0d want 0", left);
        end
        @(negedge clock);
        c0_wr_valid = 1'b1; c1_wr_valid = 1'b1;
        #1;
        checks++;
        if (mem_wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_idle got wr_valid=%b want 0", mem_wr_valid);
        end
        drive_quiet();
    endtask

    // Both clients request 1-beat reads continuously: a grant every third cycle.
    task automatic test_arbitration();
        logic [31:0] a0, a1;
        logic        w, exp_w;
        a0 = $urandom; a1 = $urandom; w = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clock);
            c0_req_valid = (cyc < 10); c1_req_valid = (cyc < 10);
            c0_req_opcode = MEM_OP_RD; c1_req_opcode = MEM_OP_RD;
            c0_req_len = 8'd0; c1_req_len = 8'd0; c0_req_addr = a0; c1_req_addr = a1;
            mem_rd_valid = 1'b1; mem_rd_bits = {$urandom, $urandom};
            c0_rd_ready = 1'b1; c1_rd_ready = 1'b1;
            #1;
            if (cyc % 3 == 0) begin
                exp_w = RrEn ? ~model_last : 1'b0;
                checks++;
                if ({c1_req_ready, c0_req_ready} !== (exp_w ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL arb_grant cyc=%0d got c1=%b c0=%b want c%0d", cyc,
                             c1_req_ready, c0_req_ready, exp_w);
                end
                model_last = exp_w;
                w = exp_w;
            end else if (cyc % 3 == 1) begin
                checks++;
                if (mem_req_valid !== 1'b1 || mem_req_addr !== (w ? a1 : a0) ||
                    {c1_req_ready, c0_req_ready} !== 2'b00) begin
                    failures++;
                    $display("FAIL arb_req cyc=%0d got v=%b addr=%h rdy=%b%b want 1 %h 00", cyc,
                             mem_req_valid, mem_req_addr, c1_req_ready, c0_req_ready,
                             w ? a1 : a0);
                end
            end else begin
                checks++;
                if ({c1_rd_valid, c0_rd_valid} !== (w ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL arb_beat cyc=%0d got rv1=%b rv0=%b want owner c%0d", cyc,
                             c1_rd_valid, c0_rd_valid, w);
                end
            end
        end
        @(negedge clock);
        drive_quiet();
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        drive_quiet();
        c1_req_valid = 1'b1; c1_req_opcode = MEM_OP_WR; c1_req_len = 8'd5;
        c1_req_addr = $urandom;
        #1;
        checks++;
        if (c1_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_accept got c1_req_ready=%b want 1", c1_req_ready);
        end
        @(negedge clock);
        c1_req_valid = 1'b0;
        @(negedge clock);
        c1_wr_valid = 1'b1; c1_wr_bits = 64'h1;
        #1;
        checks++;
        if (mem_wr_valid !== 1'b1 || mem_wr_bits !== 64'h1) begin
            failures++;
            $display("FAIL rstmid_beat1 got v=%b bits=%h want 1 1", mem_wr_valid, mem_wr_bits);
        end
        @(negedge clock);
        c1_wr_bits = 64'h2; c0_req_valid = 1'b1; c1_req_valid = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_wr_valid, mem_req_valid, mem_rd_ready, c0_req_ready, c1_req_ready} !== 5'b0 ||
            mem_wr_bits !== 64'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got wr=%b req=%b rdy=%b r0=%b r1=%b bits=%h want 0",
                     mem_wr_valid, mem_req_valid, mem_rd_ready, c0_req_ready, c1_req_ready,
                     mem_wr_bits);
        end
        @(negedge clock);
        drive_quiet();
        reset = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic test_random_mix();
        logic cl, op;
        int   len;
        for (int i = 0; i < 8; i++) begin
            cl  = 1'($urandom_range(0, 1));
            op  = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 7);
            if (op) test_write(cl, len, $urandom, {$urandom, $urandom}, 2);
            else test_read(cl, len, $urandom, 2);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive_quiet();
        model_last = 1'b1;
        test_reset();
        test_read(1'b0, 3, 32'h100, 0);
        test_write(1'b1, 1, 32'h200, 64'hA, 0);
        test_arbitration();
        test_read(1'b1, 2, $urandom, 1);
        test_read(1'b0, 0, $urandom, 0);
        test_read(1'b1, 255, $urandom, 0);
        test_write(1'b0, 0, $urandom, {$urandom, $urandom}, 0);
        test_random_mix();
        test_reset_mid();
        test_write(1'b1, 2, $urandom, {$urandom, $urandom}, 0);
        test_read(1'b0, 1, $urandom, 0);
        test_reset();
        test_arbitration();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
